// File: rtl/eu_xbuf_wr_sched_if.sv
// Producer request bus plus xbuf in_* port bundle for eu_xbuf_wr_sched.
// The scheduler takes the slave side; producers/xbuf model take the master side.
interface eu_xbuf_wr_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]             req_valid_i;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_i;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_data_i;
   logic [NUM_REQ-1:0]             req_ready_o;
   logic [ADDR_W-1:0]              xbuf_addr_o;
   logic [DATA_W-1:0]              xbuf_data_o;
   logic                           xbuf_valid_o;
   logic                           xbuf_success_i;
   logic [NUM_REQ-1:0]             grant_o;
   logic                           stall_o;

   modport slave (
      input  req_valid_i, req_addr_i, req_data_i, xbuf_success_i,
      output req_ready_o, xbuf_addr_o, xbuf_data_o, xbuf_valid_o, grant_o, stall_o
   );

   modport master (
      output req_valid_i, req_addr_i, req_data_i, xbuf_success_i,
      input  req_ready_o, xbuf_addr_o, xbuf_data_o, xbuf_valid_o, grant_o, stall_o
   );
endinterface

// File: rtl/eu_xbuf_wr_sched.sv
// Round-robin write scheduler in front of the xbuf input port, with one holding
// register per producer and a starvation guard that revokes a stuck grant.
//
// state    | meaning
// ST_IDLE  | no write on the xbuf port; pick next held channel from r_rr_ptr
// ST_ISSUE | holding register r_gidx presented to xbuf until success or revoke
module eu_xbuf_wr_sched #(
   parameter int NUM_REQ     = 4,
   parameter int STALL_LIMIT = 8,
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   eu_xbuf_wr_sched_if.slave bus
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CTR_W = $clog2(STALL_LIMIT + 1);
   localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(STALL_LIMIT - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
   localparam logic [PTR_W:0]   SUM_WRAP = (PTR_W+1)'(NUM_REQ);

   typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

   state_t                         r_state;
   logic [PTR_W-1:0]               r_rr_ptr;
   logic [PTR_W-1:0]               r_gidx;
   logic [CTR_W-1:0]               r_stall_ctr;
   logic [NUM_REQ-1:0]             r_hold_valid;
   logic [NUM_REQ-1:0][ADDR_W-1:0] r_hold_addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] r_hold_data;
   logic [NUM_REQ-1:0]             r_grant;
   logic                           r_xvalid;
   logic [ADDR_W-1:0]              r_xaddr;
   logic [DATA_W-1:0]              r_xdata;

   logic                           w_issue;
   logic                           w_success;
   logic                           w_stall;
   logic                           w_any_hold;
   logic [PTR_W-1:0]               w_sel;
   logic [PTR_W-1:0]               w_next_ptr;
   logic [PTR_W:0]                 w_sum;
   logic [PTR_W-1:0]               w_cand;
   logic [NUM_REQ-1:0]             w_ready;
   logic [NUM_REQ-1:0]             w_accept;
   logic [NUM_REQ-1:0]             w_sel_onehot;

   assign w_issue    = (r_state == ST_ISSUE);
   assign w_success  = w_issue && bus.xbuf_success_i;
   assign w_stall    = w_issue && !bus.xbuf_success_i && (r_stall_ctr == CTR_LAST);
   assign w_next_ptr = (r_gidx == PTR_LAST) ? '0 : r_gidx + PTR_W'(1);

   // A granted channel frees up in its success cycle, so it can be refilled back-to-back.
   assign w_ready  = {NUM_REQ{reset_n}} & (~r_hold_valid | (r_grant & {NUM_REQ{bus.xbuf_success_i}}));
   assign w_accept = bus.req_valid_i & w_ready;

   // Scan downward so the candidate closest to r_rr_ptr is the last to win;
   // the wrap is an explicit subtract so non-power-of-2 NUM_REQ never overflows.
   always_comb begin
      w_sel      = '0;
      w_any_hold = 1'b0;
      w_sum      = '0;
      w_cand     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
         if (w_sum >= SUM_WRAP) begin
            w_sum = w_sum - SUM_WRAP;
         end
         w_cand = w_sum[PTR_W-1:0];
         if (r_hold_valid[w_cand]) begin
            w_sel      = w_cand;
            w_any_hold = 1'b1;
         end
      end
   end

   assign w_sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_hold_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept[i]) begin
               r_hold_valid[i] <= 1'b1;
            end else if (w_success && (r_gidx == PTR_W'(i))) begin
               r_hold_valid[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_accept[i]) begin
            r_hold_addr[i] <= bus.req_addr_i[i];
            r_hold_data[i] <= bus.req_data_i[i];
         end
      end
   end

   // The granted holding register cannot reload until success, so latching its
   // contents on entry keeps the xbuf address/data stable through ISSUE.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_gidx      <= '0;
         r_stall_ctr <= '0;
         r_grant     <= '0;
         r_xvalid    <= 1'b0;
         r_xaddr     <= '0;
         r_xdata     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_hold) begin
                  r_state     <= ST_ISSUE;
                  r_gidx      <= w_sel;
                  r_grant     <= w_sel_onehot;
                  r_xvalid    <= 1'b1;
                  r_xaddr     <= r_hold_addr[w_sel];
                  r_xdata     <= r_hold_data[w_sel];
                  r_stall_ctr <= '0;
               end
            end
            ST_ISSUE: begin
               if (bus.xbuf_success_i || (r_stall_ctr == CTR_LAST)) begin
                  r_state     <= ST_IDLE;
                  r_rr_ptr    <= w_next_ptr;
                  r_stall_ctr <= '0;
                  r_grant     <= '0;
                  r_xvalid    <= 1'b0;
                  r_xaddr     <= '0;
                  r_xdata     <= '0;
               end else begin
                  r_stall_ctr <= r_stall_ctr + CTR_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready_o  = w_ready;
   assign bus.xbuf_valid_o = r_xvalid & reset_n;
   assign bus.grant_o      = r_grant & {NUM_REQ{reset_n}};
   assign bus.xbuf_addr_o  = reset_n ? r_xaddr : '0;
   assign bus.xbuf_data_o  = reset_n ? r_xdata : '0;
   assign bus.stall_o      = w_stall & reset_n;

endmodule
